ft_halt_responder: RTL

//  Core-side end of the fault-tolerance halt/replay protocol. Stops core fetch on a halt

---
 rtl/ft_halt_if.sv | 38 +++
 rtl/ft_halt_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ft_halt_if.sv
// Halt/replay bus between the FT controller (master) and the core-side
// halt responder (slave). Clock and reset are kept outside the interface.
interface ft_halt_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  halt_i;
    logic                  resume_i;
    logic                  we_spc_i;
    logic                  we_sgpr_i;
    logic [ADDR_WIDTH-1:0] replay_addr_i;
    logic [DATA_WIDTH-1:0] spc_i;
    logic [DATA_WIDTH-1:0] sgpr_i;
    logic                  core_busy_i;
    logic                  fetch_en_o;
    logic                  halted_o;
    logic                  pc_set_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  protocol_err_o;
    logic [ADDR_WIDTH:0]   replay_cnt_o;

    modport slave (
        input  halt_i, resume_i, we_spc_i, we_sgpr_i, replay_addr_i,
               spc_i, sgpr_i, core_busy_i,
        output fetch_en_o, halted_o, pc_set_o, pc_o, rf_we_o, rf_waddr_o,
               rf_wdata_o, protocol_err_o, replay_cnt_o
    );

    modport master (
        output halt_i, resume_i, we_spc_i, we_sgpr_i, replay_addr_i,
               spc_i, sgpr_i, core_busy_i,
        input  fetch_en_o, halted_o, pc_set_o, pc_o, rf_we_o, rf_waddr_o,
               rf_wdata_o, protocol_err_o, replay_cnt_o
    );
endinterface

// File: rtl/ft_halt_responder.sv
// Core-side end of the fault-tolerance halt/replay protocol.
// Stops fetch on halt, waits for the pipeline to drain, reports halted,
// forwards replayed PC/GPR writes to the core and releases it on resume.
// Optional macro FT_REPLAY_CHECK_EN: resume is only accepted after every
// GPR 1..NUM_REG-1 and the PC were written during the current halt.
module ft_halt_responder #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ft_halt_if.slave bus
);
    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic                  fetch_en_q, fetch_en_d;
    logic                  halted_q, halted_d;
    logic                  pc_set_q, pc_set_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  err_q, err_d;
    logic                  resume_ok;
    logic                  gpr_write;

    // Address 0 is the hardwired zero register, so writes to it are dropped.
    assign gpr_write = bus.we_sgpr_i && (bus.replay_addr_i != '0);

`ifdef FT_REPLAY_CHECK_EN
    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(NUM_REG - 1);

    logic [NUM_REG-1:0]  bitmap_q, bitmap_d;
    logic [ADDR_WIDTH:0] replay_cnt_q, replay_cnt_d;
    logic                pc_seen_q, pc_seen_d;

    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
        return (v == CNT_FULL) ? v : v + 1'b1;
    endfunction

    assign resume_ok        = (replay_cnt_q == CNT_FULL) && pc_seen_q;
    assign bus.replay_cnt_o = replay_cnt_q;
`else
    assign resume_ok        = 1'b1;
    assign bus.replay_cnt_o = '0;
`endif

    // Next state, next outputs and protocol checking for the halt/replay FSM.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        fetch_en_d  = fetch_en_q;
        halted_d    = halted_q;
        pc_set_d    = 1'b0;
        pc_d        = pc_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        err_d       = err_q;
`ifdef FT_REPLAY_CHECK_EN
        bitmap_d     = bitmap_q;
        replay_cnt_d = replay_cnt_q;
        pc_seen_d    = pc_seen_q;
`endif
        case (state_q)
            ST_RUN: begin
                // A simultaneous resume loses to halt and is not an error.
                if (bus.halt_i) begin
                    state_d     = ST_DRAIN;
                    fetch_en_d  = 1'b0;
                    drain_cnt_d = DRAIN_LOAD;
`ifdef FT_REPLAY_CHECK_EN
                    bitmap_d     = '0;
                    replay_cnt_d = '0;
                    pc_seen_d    = 1'b0;
`endif
                end else if (bus.resume_i) begin
                    err_d = 1'b1;
                end
                if (bus.we_spc_i || bus.we_sgpr_i) begin
                    err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Any busy cycle restarts the idle window.
                if (bus.core_busy_i) begin
                    drain_cnt_d = DRAIN_LOAD;
                end else if (drain_cnt_q <= CNT_W'(1)) begin
                    drain_cnt_d = '0;
                    state_d     = ST_HALTED;
                    halted_d    = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
                if (bus.resume_i || bus.we_spc_i || bus.we_sgpr_i) begin
                    err_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.we_spc_i) begin
                    pc_set_d = 1'b1;
                    pc_d     = bus.spc_i;
`ifdef FT_REPLAY_CHECK_EN
                    pc_seen_d = 1'b1;
`endif
                end
                if (gpr_write) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = bus.replay_addr_i;
                    rf_wdata_d = bus.sgpr_i;
`ifdef FT_REPLAY_CHECK_EN
                    if (!bitmap_q[bus.replay_addr_i]) begin
                        bitmap_d[bus.replay_addr_i] = 1'b1;
                        replay_cnt_d                = sat_inc(replay_cnt_q);
                    end
`endif
                end
                if (bus.resume_i) begin
                    if (resume_ok) begin
                        state_d = ST_RESUME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RESUME: begin
                state_d    = ST_RUN;
                halted_d   = 1'b0;
                fetch_en_d = 1'b1;
                if (bus.resume_i || bus.we_spc_i || bus.we_sgpr_i) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers with synchronous reset back to RUN.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            fetch_en_q  <= 1'b1;
            halted_q    <= 1'b0;
            pc_set_q    <= 1'b0;
            pc_q        <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            err_q       <= 1'b0;
`ifdef FT_REPLAY_CHECK_EN
            bitmap_q     <= '0;
            replay_cnt_q <= '0;
            pc_seen_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            fetch_en_q  <= fetch_en_d;
            halted_q    <= halted_d;
            pc_set_q    <= pc_set_d;
            pc_q        <= pc_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            err_q       <= err_d;
`ifdef FT_REPLAY_CHECK_EN
            bitmap_q     <= bitmap_d;
            replay_cnt_q <= replay_cnt_d;
            pc_seen_q    <= pc_seen_d;
`endif
        end
    end

    assign bus.fetch_en_o     = fetch_en_q;
    assign bus.halted_o       = halted_q;
    assign bus.pc_set_o       = pc_set_q;
    assign bus.pc_o           = pc_q;
    assign bus.rf_we_o        = rf_we_q;
    assign bus.rf_waddr_o     = rf_waddr_q;
    assign bus.rf_wdata_o     = rf_wdata_q;
    assign bus.protocol_err_o = err_q;
endmodule
